// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with same-cycle bypass and a load scoreboard.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we0/wa0/wd0       write port 0 (ALU writeback)
//   we1/wa1/wd1       write port 1 (load writeback), beats port 0 on the same address
//   ra/rd             NUM_RD packed combinational read ports with write bypass
//   rpend             pending flag per read port, masked by same-cycle writes
//   mark_en/mark_addr set the pending bit of a register whose load is in flight
//   pend_vec          raw registered scoreboard
//   dbg_regs          flattened array view, present only with REGFILE_MP_DBG_EN defined
module regfile_mp #(
    parameter int          WIDTH    = 32,
    parameter int          DEPTH    = 32,
    parameter int          AW       = 5,
    parameter int          NUM_RD   = 3,
    parameter int          ZERO_REG = 1,
    parameter int          SP_IDX   = 29,
    parameter logic [31:0] SP_INIT  = 32'h100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we0,
    input  logic [AW-1:0]           wa0,
    input  logic [WIDTH-1:0]        wd0,
    input  logic                    we1,
    input  logic [AW-1:0]           wa1,
    input  logic [WIDTH-1:0]        wd1,
    input  logic [NUM_RD*AW-1:0]    ra,
    output logic [NUM_RD*WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]       rpend,
    input  logic                    mark_en,
    input  logic [AW-1:0]           mark_addr,
    output logic [DEPTH-1:0]        pend_vec
`ifdef REGFILE_MP_DBG_EN
    ,
    output logic [DEPTH*WIDTH-1:0]  dbg_regs
`endif
);
    if (SP_IDX >= DEPTH) begin : g_bad_sp
        $error("SP_IDX must be below DEPTH");
    end
    if ((2 ** AW) < DEPTH) begin : g_bad_aw
        $error("AW too narrow for DEPTH");
    end
    if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_rd
        $error("NUM_RD must be 1..8");
    end

    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;

    function automatic logic in_range(input logic [AW-1:0] x);
        return 32'(x) < DEPTH;
    endfunction

    always_comb begin
        rf_d   = rf_q;
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (we0 && wa0 == AW'(i)) rf_d[i] = wd0;
            if (we1 && wa1 == AW'(i)) rf_d[i] = wd1;
            // clear first so a mark in the same cycle (new producer) wins
            if ((we0 && wa0 == AW'(i)) || (we1 && wa1 == AW'(i))) pend_d[i] = 1'b0;
            if (mark_en && mark_addr == AW'(i)) pend_d[i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            rf_d[0]   = '0;
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                rf_q[i] <= (i == SP_IDX) ? WIDTH'(SP_INIT) : '0;
            pend_q <= '0;
        end else begin
            rf_q   <= rf_d;
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok, hit0, hit1;
        assign a    = ra[k*AW +: AW];
        assign ok   = in_range(a);
        assign hit0 = we0 && wa0 == a;
        assign hit1 = we1 && wa1 == a;
        assign rd[k*WIDTH +: WIDTH] = (!ok || (ZERO_REG != 0 && a == '0)) ? '0 :
                                      hit1 ? wd1 : hit0 ? wd0 : rf_q[a];
        // bypassed data is already the fresh result, so it is never flagged pending
        assign rpend[k] = ok && pend_q[a] && !(hit0 || hit1);
    end

`ifdef REGFILE_MP_DBG_EN
    for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
        assign dbg_regs[g*WIDTH +: WIDTH] = rf_q[g];
    end
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (default 32-deep and a 24-deep instance sharing inputs).
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst, we0, we1, mark_en;
    logic [4:0]  wa0, wa1, mark_addr;
    logic [31:0] wd0, wd1;
    logic [14:0] ra;
    logic [95:0] rd, rd24;
    logic [2:0]  rpend, rpend24;
    logic [31:0] pend_vec;
    logic [23:0] pend24;
    int          errors = 0;
    int          checks = 0;
`ifdef REGFILE_MP_DBG_EN
    logic [1023:0] dbg;
    logic [767:0]  dbg24;
`endif

    always #5 clk = ~clk;

    regfile_mp u_rf (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rd), .rpend(rpend),
        .mark_en(mark_en), .mark_addr(mark_addr), .pend_vec(pend_vec)
`ifdef REGFILE_MP_DBG_EN
        , .dbg_regs(dbg)
`endif
    );

    regfile_mp #(.DEPTH(24), .SP_IDX(3)) u_rf24 (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rd24), .rpend(rpend24),
        .mark_en(mark_en), .mark_addr(mark_addr), .pend_vec(pend24)
`ifdef REGFILE_MP_DBG_EN
        , .dbg_regs(dbg24)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; mark_en = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; mark_addr = '0;
    endtask

    task automatic set_ra(input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0);
        ra = {a2, a1, a0};
    endtask

    initial begin
        idle();
        set_ra(0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_ra(29, 1, 0);
        #1;
        check("rst_rd2_sp", 64'(rd[64 +: 32]), 64'h100);
        check("rst_rd1", 64'(rd[32 +: 32]), 64'h0);
        check("rst_rd0", 64'(rd[0 +: 32]), 64'h0);
        check("rst_pend", 64'(pend_vec), 64'h0);
        set_ra(3, 1, 0);
        #1;
        check("rst24_sp", 64'(rd24[64 +: 32]), 64'h100);

        we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF; set_ra(0, 6, 5);
        #1;
        check("byp_rd0", 64'(rd[0 +: 32]), 64'hDEADBEEF);
        check("byp_other", 64'(rd[32 +: 32]), 64'h0);
        step();
        idle();
        #1;
        check("wr_rd0", 64'(rd[0 +: 32]), 64'hDEADBEEF);

        we0 = 1'b1; we1 = 1'b1; wa0 = 7; wa1 = 7; wd0 = 32'h11; wd1 = 32'h22; set_ra(0, 0, 7);
        #1;
        check("col_byp", 64'(rd[0 +: 32]), 64'h22);
        step();
        idle();
        #1;
        check("col_wr", 64'(rd[0 +: 32]), 64'h22);

        we0 = 1'b1; wa0 = 0; wd0 = 32'h55; set_ra(0, 0, 0);
        #1;
        check("zero_byp", 64'(rd[0 +: 32]), 64'h0);
        step();
        idle();
        #1;
        check("zero_wr", 64'(rd[0 +: 32]), 64'h0);

        mark_en = 1'b1; mark_addr = 9; set_ra(0, 0, 9);
        #1;
        check("mark_pre", 64'(rpend[0]), 64'h0);
        step();
        idle();
        #1;
        check("mark_vec", 64'(pend_vec), 64'h200);
        check("mark_rp", 64'(rpend[0]), 64'h1);
        we1 = 1'b1; wa1 = 9; wd1 = 32'h99; mark_en = 1'b1; mark_addr = 9;
        #1;
        check("setclr_rp", 64'(rpend[0]), 64'h0);
        check("setclr_rd", 64'(rd[0 +: 32]), 64'h99);
        step();
        idle();
        #1;
        check("setclr_vec", 64'(pend_vec), 64'h200);
        check("setclr_rp2", 64'(rpend[0]), 64'h1);
        we1 = 1'b1; wa1 = 9; wd1 = 32'h9A;
        #1;
        check("clr_rp", 64'(rpend[0]), 64'h0);
        step();
        idle();
        #1;
        check("clr_vec", 64'(pend_vec), 64'h0);
        check("clr_rd", 64'(rd[0 +: 32]), 64'h9A);

        mark_en = 1'b1; mark_addr = 0;
        step();
        idle();
        #1;
        check("mark_zero", 64'(pend_vec), 64'h0);

        mark_en = 1'b1; mark_addr = 12;
        step();
        idle();
        we0 = 1'b1; wa0 = 12; wd0 = 32'h12;
        step();
        idle();
        #1;
        check("clr_we0", 64'(pend_vec), 64'h0);

        mark_en = 1'b1; mark_addr = 4;
        step();
        rst = 1'b1; we0 = 1'b1; wa0 = 29; wd0 = 32'h200; mark_en = 1'b1; mark_addr = 3;
        set_ra(29, 7, 5);
        #1;
        check("rst_byp", 64'(rd[64 +: 32]), 64'h200);
        step();
        idle();
        #1;
        check("mid_sp", 64'(rd[64 +: 32]), 64'h100);
        check("mid_r7", 64'(rd[32 +: 32]), 64'h0);
        check("mid_r5", 64'(rd[0 +: 32]), 64'h0);
        check("mid_pend", 64'(pend_vec), 64'h0);
        check("mid_pend24", 64'(pend24), 64'h0);

        we0 = 1'b1; wa0 = 30; wd0 = 32'h77; mark_en = 1'b1; mark_addr = 30; set_ra(0, 0, 30);
        #1;
        check("oor_byp24", 64'(rd24[0 +: 32]), 64'h0);
        check("oor_byp32", 64'(rd[0 +: 32]), 64'h77);
        step();
        idle();
        #1;
        check("oor_rd24", 64'(rd24[0 +: 32]), 64'h0);
        check("oor_rp24", 64'(rpend24[0]), 64'h0);
        check("oor_pend24", 64'(pend24), 64'h0);
        check("oor_rd32", 64'(rd[0 +: 32]), 64'h77);
        check("oor_rp32", 64'(rpend[0]), 64'h1);

        we0 = 1'b1; wa0 = 24; wd0 = 32'h44; mark_en = 1'b1; mark_addr = 23;
        step();
        idle();
        set_ra(3, 23, 24);
        #1;
        check("edge_rd24", 64'(rd24[0 +: 32]), 64'h0);
        check("edge_pend24", 64'(pend24), 64'h800000);
        check("edge_rp24", 64'(rpend24[1]), 64'h1);
        check("edge_sp24", 64'(rd24[64 +: 32]), 64'h100);
        check("edge_rd32", 64'(rd[0 +: 32]), 64'h44);

`ifdef REGFILE_MP_DBG_EN
        for (int i = 0; i < 24; i++)
            check($sformatf("dbg24_%0d", i), 64'(dbg24[i*32 +: 32]), (i == 3) ? 64'h100 : 64'h0);
        check("dbg_r30", 64'(dbg[30*32 +: 32]), 64'h77);
        check("dbg_r29", 64'(dbg[29*32 +: 32]), 64'h100);
        check("dbg_r0", 64'(dbg[0 +: 32]), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's 32x32 register file.
- Configurable width, depth and number of read ports.
- Two write ports (ALU writeback and load writeback) with fixed priority.
- Same-cycle write-to-read bypass, so registers can be written on the rising edge.
- Per-register pending scoreboard that the hazard unit uses to stall on outstanding load results.
- Sits in the decode stage and replaces the negedge-write file.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; must be at least 2 and at most 2^AW
- AW, 5, address width; must satisfy 2^AW >= DEPTH
- NUM_RD, 3, number of combinational read ports, 1..8
- ZERO_REG, 1, when 1: register 0 reads 0, ignores writes, is never pending
- SP_IDX, 29, index loaded with SP_INIT on reset
- SP_INIT, 32'h100, reset value of register SP_IDX, truncated to WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- we0  in  1  write enable, port 0 (ALU writeback)
- wa0  in  AW  write address, port 0
- wd0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (load writeback)
- wa1  in  AW  write address, port 1
- wd1  in  WIDTH  write data, port 1
- ra  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd  out  NUM_RD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH]
- rpend  out  NUM_RD  rpend[k] = scoreboard bit of ra[k], after same-cycle clears
- mark_en  in  1  set the pending bit of mark_addr (load issued)
- mark_addr  in  AW  register whose result is outstanding
- pend_vec  out  DEPTH  raw registered scoreboard

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset state: all registers are 0, except register SP_IDX = SP_INIT. pend_vec = 0.
- Reset priority: rst overrides we0, we1 and mark_en in the same cycle. Asserting rst mid-operation discards in-flight writes and marks.
- Outputs during and after reset: rd reflects the reset contents from the cycle after rst is sampled. rd and rpend are combinational, so they have no own reset value.
- Writes: take effect on the rising edge. If we0 and we1 target the same address, port 1 wins.
- Out-of-range addresses (address >= DEPTH):
  - writes are ignored;
  - reads return 0 and rpend 0;
  - marks are ignored.
- Reads: combinational, zero latency. Priority per port k:
  1. ZERO_REG and ra[k]==0 -> 0
  2. we1 and wa1==ra[k] -> wd1
  3. we0 and wa0==ra[k] -> wd0
  4. otherwise the array contents
- Bypass applies even when rst is high. Readers must ignore data during reset.
- Scoreboard, per register i, each clock:
  - set when mark_en and mark_addr==i;
  - cleared when any we targets i;
  - set and clear in the same cycle: set wins (a new producer has been issued);
  - marking an already-pending register keeps it pending;
  - with ZERO_REG, index 0 is never set.
- rpend[k]: pend_vec[ra[k]] AND NOT (a write this cycle targets ra[k]). Bypassed data is therefore never flagged as pending.
- Storage and latency:
  - no handshake; writes complete in one cycle;
  - storage is a flop array (no RAM inference) so reset can clear it.
- Elaboration checks:
  - elaboration error if SP_IDX >= DEPTH;
  - elaboration error if 2^AW < DEPTH;
  - elaboration error if NUM_RD is outside 1..8.

Optional Feature:
- Macro: REGFILE_MP_DBG_EN.
- When defined: adds output port dbg_regs (DEPTH*WIDTH), a flattened view of the array with register i at [i*WIDTH +: WIDTH], without bypass. This is used by the simulation bench and waveform probes.
- When undefined: the port and its logic are absent and the interface is exactly as listed above.

Test Plan:
- Reset values: pulse rst for 1 cycle, then read ra = {29, 1, 0} -> rd = {0x100, 0, 0}; pend_vec = 0.
- Bypass: we0 = 1, wa0 = 5, wd0 = 0xDEADBEEF, ra[0] = 5 in the same cycle -> rd[0] = 0xDEADBEEF combinationally. With we0 = 0 on the next cycle, rd[0] is still 0xDEADBEEF.
- Write collision: we0 = we1 = 1, wa0 = wa1 = 7, wd0 = 0x11, wd1 = 0x22 -> bypass shows 0x22, and after the edge rf[7] = 0x22. Writing wa0 = 0, wd0 = 0x55 -> register 0 still reads 0.
- Scoreboard: mark_en with mark_addr = 9 -> next cycle pend_vec[9] = 1 and rpend = 1 for ra = 9. A we1 write to 9 in the same cycle as a new mark of 9 -> pend_vec[9] stays 1. A we1 write to 9 alone -> rpend is 0 that cycle and pend_vec[9] = 0 next cycle.
- Reset mid-operation: rst = 1 together with we0 = 1, wa0 = 29, wd0 = 0x200 and mark_en on 3 -> next cycle rf[29] = 0x100 and pend_vec[3] = 0.
- Out-of-range, with DEPTH = 24: write wa0 = 30, wd0 = 0x77, then read ra = 30 -> rd = 0 and rpend = 0; all dbg_regs are unchanged.
